lru_tracker: RTL

LRU_TRACKER -- requirements
Module: lru_tracker

---
 rtl/lru_pkg.sv | 24 ++
 rtl/lru_prio_enc.sv | 26 ++
 rtl/lru_tracker.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lru_pkg.sv
// lru_pkg: shared definitions for the LRU residency tracker.
//   idx_w(n) : bits needed to index n ways (at least 1)
//   cnt_w(c) : bits needed to count 0..c
//   lru_ev_e : the single event applied to the tracker state in a cycle
package lru_pkg;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_HIT,
    EV_FILL,
    EV_EVICT,
    EV_INV,
    EV_FLUSH
  } lru_ev_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int c);
    return $clog2(c + 1);
  endfunction

endpackage

// File: rtl/lru_prio_enc.sv
// lru_prio_enc: lowest-set-bit priority encoder for the access request vector.
//   req   : request bits, one per way
//   valid : at least one bit of req is set
//   idx   : index of the lowest set bit (0 when valid=0)
module lru_prio_enc #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/lru_tracker.sv
// lru_tracker: tracks which ways are resident and their recency order,
// evicting the least-recently-used way when a miss arrives at full capacity.
//   clk, rst             : clock, async active-high reset
//   tick                 : qualifies acc_req
//   acc_req              : per-way access request (lowest set bit wins)
//   inv_valid, inv_idx   : invalidate one way (ignored with an accepted access)
//   flush                : clear all residency (highest priority)
//   resident, occupancy  : registered residency flags and resident count
//   lru_idx, lru_valid   : least-recently-used resident way
//   hit                  : pulse, accepted access hit a resident way
//   evict_valid/evict_idx: pulse and index of the way displaced by a miss
//
// event    | meaning
// EV_NONE  | nothing changes
// EV_HIT   | accessed way resident, moves to rank 0
// EV_FILL  | miss with free capacity, inserted at rank 0
// EV_EVICT | miss at capacity, oldest way displaced
// EV_INV   | resident way removed, ranks behind it close up
// EV_FLUSH | everything cleared
module lru_tracker
  import lru_pkg::*;
#(
  parameter int NUM_WAYS = 5,
  parameter int CAPACITY = 4,
  localparam int IDX_W = idx_w(NUM_WAYS),
  localparam int CNT_W = cnt_w(CAPACITY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [NUM_WAYS-1:0] acc_req,
  input  logic                inv_valid,
  input  logic [IDX_W-1:0]    inv_idx,
  input  logic                flush,
  output logic [NUM_WAYS-1:0] resident,
  output logic [CNT_W-1:0]    occupancy,
  output logic [IDX_W-1:0]    lru_idx,
  output logic                lru_valid,
  output logic                hit,
  output logic                evict_valid,
  output logic [IDX_W-1:0]    evict_idx
);

  logic [NUM_WAYS-1:0] res_q, res_n;
  logic [IDX_W-1:0]    rank_q [NUM_WAYS];
  logic [IDX_W-1:0]    rank_n [NUM_WAYS];
  logic [CNT_W-1:0]    occ_q, occ_n, occ_m1;
  logic [IDX_W-1:0]    lru_q, lru_n;
  logic                lru_valid_q;
  logic                hit_q, evict_valid_q;
  logic [IDX_W-1:0]    evict_idx_q, evict_idx_n;

  logic                sel_valid;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_res, inv_res;
  logic [IDX_W-1:0]    sel_rank, inv_rank, victim, lru_rank;
  logic                full;
  lru_ev_e             ev;

  lru_prio_enc #(
    .N     (NUM_WAYS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req   (acc_req),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  // Lookups are done by loop rather than direct indexing so that an
  // out-of-range inv_idx simply finds nothing.
  always_comb begin
    sel_res  = 1'b0;
    sel_rank = '0;
    inv_res  = 1'b0;
    inv_rank = '0;
    victim   = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (IDX_W'(i) == sel_idx) begin
        sel_res  = res_q[i];
        sel_rank = rank_q[i];
      end
      if (IDX_W'(i) == inv_idx) begin
        inv_res  = res_q[i];
        inv_rank = rank_q[i];
      end
      if (res_q[i] && rank_q[i] == IDX_W'(CAPACITY - 1))
        victim = IDX_W'(i);
    end
  end

  assign full = (occ_q == CNT_W'(CAPACITY));

  always_comb begin
    ev = EV_NONE;
    if (flush)
      ev = EV_FLUSH;
    else if (tick && sel_valid)
      ev = sel_res ? EV_HIT : (full ? EV_EVICT : EV_FILL);
    else if (inv_valid && inv_res)
      ev = EV_INV;
  end

  // Non-resident ways are kept at rank 0 so the rank table stays canonical.
  always_comb begin
    res_n       = res_q;
    occ_n       = occ_q;
    evict_idx_n = '0;
    for (int i = 0; i < NUM_WAYS; i++) rank_n[i] = rank_q[i];

    for (int i = 0; i < NUM_WAYS; i++) begin
      unique case (ev)
        EV_HIT: begin
          if (IDX_W'(i) == sel_idx)
            rank_n[i] = '0;
          else if (res_q[i] && rank_q[i] < sel_rank)
            rank_n[i] = rank_q[i] + 1'b1;
        end
        EV_FILL, EV_EVICT: begin
          if (IDX_W'(i) == sel_idx) begin
            res_n[i]  = 1'b1;
            rank_n[i] = '0;
          end else if (ev == EV_EVICT && res_q[i] &&
                       rank_q[i] == IDX_W'(CAPACITY - 1)) begin
            res_n[i]  = 1'b0;
            rank_n[i] = '0;
          end else if (res_q[i]) begin
            rank_n[i] = rank_q[i] + 1'b1;
          end
        end
        EV_INV: begin
          if (IDX_W'(i) == inv_idx) begin
            res_n[i]  = 1'b0;
            rank_n[i] = '0;
          end else if (res_q[i] && rank_q[i] > inv_rank) begin
            rank_n[i] = rank_q[i] - 1'b1;
          end
        end
        EV_FLUSH: begin
          res_n[i]  = 1'b0;
          rank_n[i] = '0;
        end
        default: ;
      endcase
    end

    unique case (ev)
      EV_FILL:  occ_n = occ_q + CNT_W'(1);
      EV_INV:   occ_n = occ_q - CNT_W'(1);
      EV_FLUSH: occ_n = '0;
      default:  ;
    endcase

    if (ev == EV_EVICT) evict_idx_n = victim;
  end

  // LRU is derived from the next state so it can be registered with it.
  // When occ_n is 0 nothing is resident, so the search finds nothing.
  always_comb begin
    occ_m1   = occ_n - CNT_W'(1);
    lru_rank = IDX_W'(occ_m1);
    lru_n    = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (res_n[i] && rank_n[i] == lru_rank) lru_n = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q         <= '0;
      occ_q         <= '0;
      lru_q         <= '0;
      lru_valid_q   <= 1'b0;
      hit_q         <= 1'b0;
      evict_valid_q <= 1'b0;
      evict_idx_q   <= '0;
      for (int i = 0; i < NUM_WAYS; i++) rank_q[i] <= '0;
    end else begin
      res_q         <= res_n;
      occ_q         <= occ_n;
      lru_q         <= lru_n;
      lru_valid_q   <= (occ_n != '0);
      hit_q         <= (ev == EV_HIT);
      evict_valid_q <= (ev == EV_EVICT);
      evict_idx_q   <= evict_idx_n;
      for (int i = 0; i < NUM_WAYS; i++) rank_q[i] <= rank_n[i];
    end
  end

  assign resident    = res_q;
  assign occupancy   = occ_q;
  assign lru_idx     = lru_q;
  assign lru_valid   = lru_valid_q;
  assign hit         = hit_q;
  assign evict_valid = evict_valid_q;
  assign evict_idx   = evict_idx_q;

endmodule
